// File: rtl/imem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : imem_pkg
// Brief  : Shared types and constants for the instruction-memory loader.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package imem_pkg;

  // Default instruction-memory geometry: 512 words of 32 bits.
  localparam int IMEM_ADDR_W    = 9;
  localparam int IMEM_DATA_W    = 32;

  // A word is always assembled from this many bytes.
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } imem_state_e;

  // True when the byte counter points at the last byte slot of a word.
  function automatic logic is_last_byte(input logic [BYTE_CNT_W-1:0] cnt);
    return cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : imem_byte_packer
// Brief  : Assembles little-endian bytes into a word; flags the 4th byte.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic [DATA_W-1:0] word,
  output logic              word_ready
);

  logic [DATA_W-1:0]     word_q, word_d;
  logic [BYTE_CNT_W-1:0] cnt_q,  cnt_d;

  // Shift each accepted byte in from the top so that after four bytes the
  // first one lands in bits 7:0 (little-endian assembly).
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      word_d = {in_data, word_q[DATA_W-1:8]};
      cnt_d  = cnt_q + BYTE_CNT_W'(1);
    end
  end

  // Packer storage; the counter wraps back to 0 on the 4th byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_ready = accept & ~clear & is_last_byte(cnt_q);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : imem_loader
// Brief  : Loads a byte stream into instruction memory, one word per
//          4 accepted bytes, while holding the fetch stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              hold_fetch,
  output logic              done
);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   words_q, words_d;

  logic              transfer;
  logic              start_accept;
  logic              word_ready;
  logic [DATA_W-1:0] packed_word;

  // Bytes are only taken while collecting; WRITE is a one-cycle bubble.
  assign in_ready     = (state_q == ST_COLLECT);
  assign transfer     = in_valid & in_ready;
  assign start_accept = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  imem_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .accept     (transfer),
    .in_data    (in_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  // Next-state, address and remaining-word bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
            addr_d  = base_addr;
            words_d = length;
          end
        end
      end
      ST_COLLECT: begin
        if (word_ready) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Address wraps naturally modulo 2^ADDR_W.
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q - (ADDR_W + 1)'(1);
        state_d = (words_q == (ADDR_W + 1)'(1)) ? ST_DONE : ST_COLLECT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset wins over everything, mid-load included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  // All memory-side outputs come straight from flops, never from in_data.
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = packed_word;
  assign hold_fetch = (state_q == ST_COLLECT) | (state_q == ST_WRITE);
  assign done       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_imem_loader
// Brief  : Directed self-checking bench for imem_loader.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  length = '0;
  logic [8:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        hold_fetch;
  logic        done;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .length     (length),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .hold_fetch (hold_fetch),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  bit          hold_seen;

  // Cycle counter.
  always @(posedge clk) cyc++;

  // Write logger, sampled mid-cycle; in_ready must be low on every write.
  always @(negedge clk) begin
    if (hold_fetch === 1'b1) hold_seen = 1'b1;
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_write: in_ready=%b required 0", in_ready);
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    hold_seen = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] len, input logic [8:0] base);
    start     = 1'b1;
    length    = len;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
  endtask

  task automatic idle_gap(input int n);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (n) tick();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    in_valid = 1'b0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: done=%b required 1 within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks += 6;
    if (in_ready   !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    if (mem_we     !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    if (mem_addr   !== 9'd0)  begin n_fail++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
    if (mem_wdata  !== 32'd0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    if (hold_fetch !== 1'b0)  begin n_fail++; $display("FAIL rst_hold_fetch: got %b required 0", hold_fetch); end
    if (done       !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    clear_log();
    do_start(10'd1, 9'd0);
    n_checks++;
    if (hold_fetch !== 1'b1) begin n_fail++; $display("FAIL single_hold_on: got %b required 1", hold_fetch); end
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done(20);
    tick();
    n_checks += 5;
    if (wr_addr.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d required 1", wr_addr.size()); end
    if (wr_addr.size() >= 1 && wr_addr[0] != 0) begin n_fail++; $display("FAIL single_addr: got %0d required 0", wr_addr[0]); end
    if (wr_data.size() >= 1 && wr_data[0] !== 32'h0000_0013) begin n_fail++; $display("FAIL single_data: got %h required 00000013", wr_data[0]); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b required 1", done); end
    if (hold_fetch !== 1'b0) begin n_fail++; $display("FAIL single_hold_off: got %b required 0", hold_fetch); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3] = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09};
    clear_log();
    do_start(10'd3, 9'd5);
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    wait_done(20);
    n_checks++;
    if (wr_addr.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d required 3", wr_addr.size()); end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      n_checks += 2;
      if (wr_addr[i] != 5 + i) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d required %0d", i, wr_addr[i], 5 + i); end
      if (wr_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", i, wr_data[i], exp_d[i]); end
    end
    for (int i = 1; i < 3 && i < wr_cyc.size(); i++) begin
      n_checks++;
      if (wr_cyc[i] - wr_cyc[i-1] != 5) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d required 5", i, wr_cyc[i] - wr_cyc[i-1]); end
    end
  endtask

  task automatic test_wrap();
    clear_log();
    do_start(10'd2, 9'd511);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done(20);
    n_checks++;
    if (wr_addr.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d required 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_checks += 4;
      if (wr_addr[0] != 511) begin n_fail++; $display("FAIL wrap_addr0: got %0d required 511", wr_addr[0]); end
      if (wr_addr[1] != 0)   begin n_fail++; $display("FAIL wrap_addr1: got %0d required 0", wr_addr[1]); end
      if (wr_data[0] !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL wrap_data0: got %h required ddccbbaa", wr_data[0]); end
      if (wr_data[1] !== 32'h4433_2211) begin n_fail++; $display("FAIL wrap_data1: got %h required 44332211", wr_data[1]); end
    end
  endtask

  task automatic test_zero_length();
    clear_log();
    do_start(10'd0, 9'd17);
    n_checks += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b required 1", done); end
    if (hold_fetch !== 1'b0) begin n_fail++; $display("FAIL zero_hold: got %b required 0", hold_fetch); end
    repeat (5) tick();
    n_checks += 2;
    if (wr_addr.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d required 0", wr_addr.size()); end
    if (hold_seen != 1'b0) begin n_fail++; $display("FAIL zero_hold_seen: got %b required 0", hold_seen); end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    do_start(10'd3, 9'h020);
    send_byte(8'h11); send_byte(8'h12); send_byte(8'h13); send_byte(8'h14);
    send_byte(8'h21); send_byte(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h23;
    reset    = 1'b1;
    tick();
    n_checks += 6;
    if (in_ready   !== 1'b0)  begin n_fail++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    if (mem_we     !== 1'b0)  begin n_fail++; $display("FAIL mid_mem_we: got %b required 0", mem_we); end
    if (mem_addr   !== 9'd0)  begin n_fail++; $display("FAIL mid_mem_addr: got %0d required 0", mem_addr); end
    if (mem_wdata  !== 32'd0) begin n_fail++; $display("FAIL mid_mem_wdata: got %h required 0", mem_wdata); end
    if (hold_fetch !== 1'b0)  begin n_fail++; $display("FAIL mid_hold: got %b required 0", hold_fetch); end
    if (done       !== 1'b0)  begin n_fail++; $display("FAIL mid_done: got %b required 0", done); end
    reset   = 1'b0;
    in_data = 8'h33;
    repeat (8) tick();
    in_valid = 1'b0;
    n_checks++;
    if (wr_addr.size() != 1) begin n_fail++; $display("FAIL mid_count: got %0d required 1", wr_addr.size()); end
    if (wr_addr.size() >= 1) begin
      n_checks += 2;
      if (wr_addr[0] != 32) begin n_fail++; $display("FAIL mid_addr0: got %0d required 32", wr_addr[0]); end
      if (wr_data[0] !== 32'h1413_1211) begin n_fail++; $display("FAIL mid_data0: got %h required 14131211", wr_data[0]); end
    end
    do_start(10'd1, 9'd3);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    wait_done(20);
    n_checks++;
    if (wr_addr.size() != 2) begin n_fail++; $display("FAIL reload_count: got %0d required 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_checks += 2;
      if (wr_addr[1] != 3) begin n_fail++; $display("FAIL reload_addr: got %0d required 3", wr_addr[1]); end
      if (wr_data[1] !== 32'h0807_0605) begin n_fail++; $display("FAIL reload_data: got %h required 08070605", wr_data[1]); end
    end
  endtask

  task automatic test_stall_and_start_ignored();
    logic [31:0] exp_d [3] = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09};
    clear_log();
    do_start(10'd3, 9'd5);
    for (int i = 1; i <= 12; i++) begin
      idle_gap(int'($urandom_range(0, 3)));
      if (i == 7) begin
        start     = 1'b1;
        length    = 10'd1;
        base_addr = 9'd100;
        tick();
        start     = 1'b0;
      end
      send_byte(8'(i));
    end
    wait_done(40);
    repeat (5) tick();
    n_checks++;
    if (wr_addr.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d required 3", wr_addr.size()); end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      n_checks += 2;
      if (wr_addr[i] != 5 + i) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d required %0d", i, wr_addr[i], 5 + i); end
      if (wr_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h required %h", i, wr_data[i], exp_d[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wrap();
    test_zero_length();
    test_reset_mid_load();
    test_stall_and_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
